uart_rx_fifo_ctrl: RTL and testbench
====================================

# uart_rx_fifo_ctrl

Read-side controller for the 16-entry UART receive FIFO. It turns single-cycle CPU read, status-read and flush requests into correctly sequenced FIFO pop and error-clear strobes. It also generates the receive interrupts: trigger-level, character-timeout and line-status. It sits between the FIFO and the UART bus-register block, and is the only driver of the FIFO's `fifoRe` and `clearError` inputs.

## Interface
- `TIMEOUT_CHARS`, default 4: character times without activity before `irqTimeout`. Legal range 1..7.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `triggerSel`  in  2  trigger-level select: 0→1 entry, 1→4, 2→8, 3→14.
- `cpuRead`  in  1  single-cycle pulse requesting one received byte.
- `lsrRead`  in  1  single-cycle pulse: CPU read the line-status register.
- `flushReq`  in  1  single-cycle pulse requesting a FIFO flush.
- `charTick`  in  1  one-cycle pulse per received character time (from the baud generator).
- `rxWe`  in  1  write strobe from the receiver; the same signal drives the FIFO `fifoWe`.
- `fifoEmpty`, `fifoFull`  in  1  FIFO status flags.
- `nrOfEntries`  in  5  FIFO occupancy, 0..16.
- `fifoData`  in  8  FIFO head data (combinational read).
- `frameErrorIn`, `parityErrorIn`, `breakIn`  in  1 each  error flags of the FIFO head entry.
- `fifoError`  in  1  FIFO's registered "any entry has an error" flag.
- `fifoRe`  out  1  FIFO pop strobe.
- `clearError`  out  1  clear the error flags of the head entry.
- `rdValid`  out  1  one-cycle pulse: `rdData`/`rdStatus` hold a completed read.
- `rdData`  out  8  byte returned by the last read.
- `rdStatus`  out  4  {empty, break, parity, frame} for the last read.
- `flushBusy`  out  1  high while a flush is in progress.
- `irqData`, `irqTimeout`, `irqLineStatus`, `irq`  out  1 each  interrupt sources; `irq` is their OR.

## Operation
- **FSM states:** IDLE, POP, FLUSH.
- **IDLE transitions:**
  - `flushReq`=1 → FLUSH. `flushReq` has priority over `cpuRead` in the same cycle.
  - Otherwise `cpuRead`=1 → POP.
- **POP:** lasts exactly one cycle, then → IDLE, or → FLUSH if a flush is pending.
  - `fifoRe` = ~`fifoEmpty`.
  - At the end of the POP cycle:
    - `rdData` ← `fifoData`, or 0 if empty.
    - `rdStatus` ← {`fifoEmpty`, `breakIn`, `parityErrorIn`, `frameErrorIn`}; the error bits are 0 if empty.
    - `rdValid` is set for exactly one cycle.
- **FLUSH:**
  - `fifoRe` = ~`fifoEmpty` every cycle.
  - `clearError` is high in the first FLUSH cycle.
  - A 5-bit pop counter counts cycles in FLUSH. Exit → IDLE when `fifoEmpty`=1 is sampled, or after 16 cycles, whichever comes first. The 16-cycle cap bounds the flush under continuous `rxWe`.
  - `flushBusy` = (state==FLUSH).
- **Requests in non-IDLE states:**
  - `flushReq` during POP is latched as pending.
  - `cpuRead` and `flushReq` arriving during FLUSH are dropped.
  - `cpuRead` during POP is dropped. The CPU must wait for `rdValid`.
- **Empty-pop invariant:** `fifoRe` is never 1 while `fifoEmpty`=1, including when `rxWe`=1. The FIFO treats simultaneous read and write as a pop even when empty.
- **Trigger level:** `irqData` is registered as (`nrOfEntries` ≥ selected level).
- **Character timeout:**
  - A 3-bit counter clears when `rxWe`, `fifoRe` or `fifoEmpty` is 1.
  - Otherwise it increments on `charTick`, saturating at `TIMEOUT_CHARS`.
  - `irqTimeout` is registered as (count==`TIMEOUT_CHARS`) & ~`fifoEmpty`.
- **Line status:**
  - `irqLineStatus` is sticky; it sets when `fifoError`=1.
  - On `lsrRead`:
    - `clearError` pulses in the next cycle.
    - `irqLineStatus` clears on the same edge.
    - Setting is masked for 2 cycles, covering the FIFO's error-flag latency. Clear wins over set.
- **Shared clear:** `clearError` = (LSR clear pulse) | (first FLUSH cycle).
- **Combined interrupt:** `irq` is registered as the OR of the three sources.

## Timing
- **Reset:** asynchronous; reset asserted → state IDLE; every output and counter is 0, including `rdData` and `rdStatus`. A reset during POP or FLUSH aborts it immediately, with no further `fifoRe`.
- **Read latency:** `cpuRead` sampled at edge T → `fifoRe` high during cycle T+1 → `rdValid` high during T+2.
- **Back-to-back reads:** maximum read throughput is one byte per 2 cycles.
- **`fifoRe` timing:** combinational from the state and `fifoEmpty`.
- **Interrupt latency:**
  - `irqData` and `irqTimeout` lag their conditions by 1 cycle.
  - `irq` lags by 2 cycles.
- **Flush length:** a flush of N entries (N ≤ 16, no concurrent writes) takes N+1 cycles from `flushReq` to `flushBusy` falling.

## Test plan
- Write 0x41, 0x42; `cpuRead` twice, 3 cycles apart → `rdValid` with `rdData`=0x41 then 0x42, `rdStatus`=0; `nrOfEntries` 2→0; exactly 2 `fifoRe` pulses.
- `cpuRead` on empty FIFO with `rxWe`=1 in the POP cycle → `fifoRe` stays 0; `rdStatus`=4'b1000, `rdData`=0; the written byte remains, `nrOfEntries`=1.
- `triggerSel`=1; write 3 then 4 bytes → `irqData` 0 at 3 entries, 1 one cycle after the 4th write; read one byte → `irqData` drops.
- 1 byte, `TIMEOUT_CHARS`=4, 4 `charTick`s with no activity → `irqTimeout`=1 after the 4th; `rxWe` resets the counter; reading the byte clears `irqTimeout`.
- Write a byte with `parityErrorIn`=1 → `irqLineStatus`=1; `lsrRead` → `clearError` pulse next cycle; `irqLineStatus`=0 and stays 0; read returns `rdStatus`=4'b0010.
- Fill 16 entries, `flushReq` with `cpuRead` in the same cycle → FLUSH entered, read ignored; 16 pops; `flushBusy` high 17 cycles. Assert reset mid-flush → all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Read-side controller for the 16-entry UART receive FIFO. Converts single-cycle
// CPU requests (byte read, line-status read, flush) into FIFO pop and
// error-clear strobes, and generates the receive interrupts.
//
// Parameters
//   TIMEOUT_CHARS  character times without activity before irqTimeout (1..7)
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   triggerSel     trigger level select: 0->1, 1->4, 2->8, 3->14 entries
//   cpuRead        one-cycle request for one received byte
//   lsrRead        one-cycle pulse: CPU read the line-status register
//   flushReq       one-cycle request to flush the FIFO
//   charTick       one pulse per received character time
//   rxWe           receiver write strobe (also the FIFO write strobe)
//   fifoEmpty      FIFO empty flag
//   fifoFull       FIFO full flag
//   nrOfEntries    FIFO occupancy, 0..16
//   fifoData       FIFO head data
//   frameErrorIn   head entry frame error
//   parityErrorIn  head entry parity error
//   breakIn        head entry break condition
//   fifoError      FIFO "some entry has an error" flag
//   fifoRe         FIFO pop strobe
//   clearError     clear error flags of the head entry
//   rdValid        one-cycle pulse: rdData/rdStatus hold a completed read
//   rdData         byte returned by the last read
//   rdStatus       {empty, break, parity, frame} of the last read
//   flushBusy      high while a flush is running
//   irqData        trigger-level interrupt
//   irqTimeout     character-timeout interrupt
//   irqLineStatus  line-status interrupt (sticky until lsrRead)
//   irq            OR of the three interrupt sources
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] triggerSel,
    input  logic       cpuRead,
    input  logic       lsrRead,
    input  logic       flushReq,
    input  logic       charTick,
    input  logic       rxWe,
    input  logic       fifoEmpty,
    input  logic       fifoFull,
    input  logic [4:0] nrOfEntries,
    input  logic [7:0] fifoData,
    input  logic       frameErrorIn,
    input  logic       parityErrorIn,
    input  logic       breakIn,
    input  logic       fifoError,
    output logic       fifoRe,
    output logic       clearError,
    output logic       rdValid,
    output logic [7:0] rdData,
    output logic [3:0] rdStatus,
    output logic       flushBusy,
    output logic       irqData,
    output logic       irqTimeout,
    output logic       irqLineStatus,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        FLUSH = 2'd2
    } ctrlStateT;

    localparam logic [2:0] TIMEOUT_LIM = 3'(TIMEOUT_CHARS);
    // The flush gives up once 16 cycles have elapsed so that a receiver
    // writing every cycle cannot keep it alive forever.
    localparam logic [4:0] FLUSH_CAP   = 5'd16;

    ctrlStateT  stateReg, stateNext;
    logic [4:0] popCountReg;
    logic       rdValidReg;
    logic [7:0] rdDataReg;
    logic [3:0] rdStatusReg;
    logic [2:0] quietCountReg;
    logic       irqDataReg, irqTimeoutReg, irqLineStatusReg, irqReg;
    logic       lsrClearReg;
    logic [1:0] lsrMaskReg;
    logic [4:0] trigLevel;
    logic [2:0] headErr, headErrGated;

    // Head error flags are meaningless when the FIFO is empty; force them low.
    assign headErr = {breakIn, parityErrorIn, frameErrorIn};
    for (genvar gi = 0; gi < 3; gi++) begin : g_errGate
        assign headErrGated[gi] = headErr[gi] & ~fifoEmpty;
    end

    // ------------------------------------------------------------------
    // Request sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        fifoRe    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (flushReq) begin
                    stateNext = FLUSH;
                end else if (cpuRead) begin
                    stateNext = POP;
                end
            end
            POP: begin
                // Never pop an empty FIFO: it would treat a concurrent write
                // plus read as a pop and lose the incoming byte.
                fifoRe = ~fifoEmpty;
                // A flush requested during the pop follows straight after it;
                // a second cpuRead here is dropped.
                stateNext = flushReq ? FLUSH : IDLE;
            end
            FLUSH: begin
                fifoRe = ~fifoEmpty;
                if (fifoEmpty || (popCountReg == FLUSH_CAP)) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Cycles spent in the current flush; zero outside FLUSH so that a zero
    // count inside FLUSH marks the first flush cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            popCountReg <= '0;
        end else if ((stateReg == FLUSH) && (stateNext == FLUSH)) begin
            popCountReg <= popCountReg + 5'd1;
        end else begin
            popCountReg <= '0;
        end
    end

    assign flushBusy  = (stateReg == FLUSH);
    assign clearError = lsrClearReg | ((stateReg == FLUSH) && (popCountReg == 5'd0));

    // ------------------------------------------------------------------
    // Read result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdValidReg  <= 1'b0;
            rdDataReg   <= '0;
            rdStatusReg <= '0;
        end else begin
            rdValidReg <= (stateReg == POP);
            if (stateReg == POP) begin
                rdDataReg   <= fifoEmpty ? 8'h00 : fifoData;
                rdStatusReg <= {fifoEmpty, headErrGated};
            end
        end
    end

    assign rdValid  = rdValidReg;
    assign rdData   = rdDataReg;
    assign rdStatus = rdStatusReg;

    // ------------------------------------------------------------------
    // Trigger-level interrupt
    // ------------------------------------------------------------------
    always_comb begin
        case (triggerSel)
            2'd0:    trigLevel = 5'd1;
            2'd1:    trigLevel = 5'd4;
            2'd2:    trigLevel = 5'd8;
            default: trigLevel = 5'd14;
        endcase
    end

    // ------------------------------------------------------------------
    // Character timeout: counts idle character times while data waits.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quietCountReg <= '0;
        end else if (rxWe || fifoRe || fifoEmpty) begin
            quietCountReg <= '0;
        end else if (charTick && (quietCountReg != TIMEOUT_LIM)) begin
            quietCountReg <= quietCountReg + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Line-status interrupt. After an LSR read the FIFO's error flag takes
    // two cycles to reflect the clear, so setting is masked meanwhile.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lsrClearReg      <= 1'b0;
            lsrMaskReg       <= '0;
            irqLineStatusReg <= 1'b0;
        end else begin
            lsrClearReg <= lsrRead;
            if (lsrRead) begin
                lsrMaskReg <= 2'd2;
            end else if (lsrMaskReg != 2'd0) begin
                lsrMaskReg <= lsrMaskReg - 2'd1;
            end
            if (lsrRead) begin
                irqLineStatusReg <= 1'b0;
            end else if (fifoError && (lsrMaskReg == 2'd0)) begin
                irqLineStatusReg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered interrupt outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irqDataReg    <= 1'b0;
            irqTimeoutReg <= 1'b0;
            irqReg        <= 1'b0;
        end else begin
            // A full FIFO satisfies every trigger level.
            irqDataReg    <= (nrOfEntries >= trigLevel) | fifoFull;
            irqTimeoutReg <= (quietCountReg == TIMEOUT_LIM) & ~fifoEmpty;
            irqReg        <= irqDataReg | irqTimeoutReg | irqLineStatusReg;
        end
    end

    assign irqData       = irqDataReg;
    assign irqTimeout    = irqTimeoutReg;
    assign irqLineStatus = irqLineStatusReg;
    assign irq           = irqReg;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
// Bench for uart_rx_fifo_ctrl. A queue-based FIFO surrounds the controller and
// reacts to its strobes; a timestamp-based reference model predicts every
// output each cycle. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;

    localparam int TO = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] triggerSel = 2'd0;
    logic       cpuRead = 1'b0, lsrRead = 1'b0, flushReq = 1'b0, charTick = 1'b0, rxWe = 1'b0;
    logic       fifoEmpty, fifoFull;
    logic [4:0] nrOfEntries;
    logic [7:0] fifoData;
    logic       frameErrorIn, parityErrorIn, breakIn, fifoError;
    logic       fifoRe, clearError, rdValid, flushBusy;
    logic [7:0] rdData;
    logic [3:0] rdStatus;
    logic       irqData, irqTimeout, irqLineStatus, irq;

    always #5 clock = ~clock;

    uart_rx_fifo_ctrl #(.TIMEOUT_CHARS(TO)) dut (
        .clock(clock), .reset(reset), .triggerSel(triggerSel),
        .cpuRead(cpuRead), .lsrRead(lsrRead), .flushReq(flushReq),
        .charTick(charTick), .rxWe(rxWe), .fifoEmpty(fifoEmpty),
        .fifoFull(fifoFull), .nrOfEntries(nrOfEntries), .fifoData(fifoData),
        .frameErrorIn(frameErrorIn), .parityErrorIn(parityErrorIn),
        .breakIn(breakIn), .fifoError(fifoError), .fifoRe(fifoRe),
        .clearError(clearError), .rdValid(rdValid), .rdData(rdData),
        .rdStatus(rdStatus), .flushBusy(flushBusy), .irqData(irqData),
        .irqTimeout(irqTimeout), .irqLineStatus(irqLineStatus), .irq(irq)
    );

    // FIFO environment
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;   // {break, parity, frame}
        logic       rep;   // error already reported via clearError
    } entryT;
    entryT fifoQ[$];
    logic [7:0] wrData = 8'h00;
    logic [2:0] wrErr  = 3'b000;

    // Reference model state (cycle-stamped events)
    int  cyc = 0;
    int  popCyc = -10, validAt = -10, lastLsr = -10, flushStart = 0;
    bit  flushOn = 0;
    logic [7:0] expData = 8'h00;
    logic [3:0] expStat = 4'h0;
    int  quiet = 0;
    bit  eIrqData = 0, eIrqTo = 0, eIrqLs = 0, eIrq = 0;

    int  total = 0, bad = 0;
    int  rePulses = 0, flushCycles = 0;
    logic [11:0] readLog[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int level(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 14;
        endcase
    endfunction

    task automatic driveFifo();
        int n;
        bit anyErr;
        n = fifoQ.size();
        anyErr = 0;
        fifoEmpty   = (n == 0);
        fifoFull    = (n == 16);
        nrOfEntries = 5'(n);
        if (n > 0) {fifoData, breakIn, parityErrorIn, frameErrorIn} = {fifoQ[0].data, fifoQ[0].err};
        else       {fifoData, breakIn, parityErrorIn, frameErrorIn} = {8'hA5, 3'b111};
        foreach (fifoQ[i]) if (fifoQ[i].err != 3'b000 && !fifoQ[i].rep) anyErr = 1;
        fifoError = anyErr;
    endtask

    task automatic clearModel();
        popCyc = -10; validAt = -10; lastLsr = -10; flushOn = 0;
        quiet = 0; eIrqData = 0; eIrqTo = 0; eIrqLs = 0; eIrq = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".fifoRe"},        32'(fifoRe), 0);
        checkVal({tag, ".clearError"},    32'(clearError), 0);
        checkVal({tag, ".rdValid"},       32'(rdValid), 0);
        checkVal({tag, ".rdData"},        32'(rdData), 0);
        checkVal({tag, ".rdStatus"},      32'(rdStatus), 0);
        checkVal({tag, ".flushBusy"},     32'(flushBusy), 0);
        checkVal({tag, ".irqData"},       32'(irqData), 0);
        checkVal({tag, ".irqTimeout"},    32'(irqTimeout), 0);
        checkVal({tag, ".irqLineStatus"}, 32'(irqLineStatus), 0);
        checkVal({tag, ".irq"},           32'(irq), 0);
    endtask

    // One clock cycle: check outputs against the model mid-cycle, advance the
    // model, let the edge pass, then update the FIFO from the DUT's strobes.
    task automatic cycle();
        bit busyPop, busyFlush, empty, eRe, eClr, idle;
        bit nData, nTo, nLs, nIrq, doRe, doWe, doClr;
        entryT e;
        @(negedge clock);
        busyPop   = (popCyc == cyc);
        busyFlush = flushOn;
        empty     = (fifoQ.size() == 0);
        eRe  = (busyPop || busyFlush) && !empty;
        eClr = (lastLsr == cyc - 1) || (busyFlush && flushStart == cyc);
        checkVal("fifoRe",        32'(fifoRe), 32'(eRe));
        checkVal("clearError",    32'(clearError), 32'(eClr));
        checkVal("flushBusy",     32'(flushBusy), 32'(busyFlush));
        checkVal("rdValid",       32'(rdValid), 32'(validAt == cyc));
        checkVal("irqData",       32'(irqData), 32'(eIrqData));
        checkVal("irqTimeout",    32'(irqTimeout), 32'(eIrqTo));
        checkVal("irqLineStatus", 32'(irqLineStatus), 32'(eIrqLs));
        checkVal("irq",           32'(irq), 32'(eIrq));
        if (validAt == cyc) begin
            checkVal("rdData",   32'(rdData), 32'(expData));
            checkVal("rdStatus", 32'(rdStatus), 32'(expStat));
            readLog.push_back({rdStatus, rdData});
            $display("read  cycle=%0d data=%02h status=%04b", cyc, rdData, rdStatus);
        end
        if (fifoRe) rePulses++;
        if (flushBusy) flushCycles++;

        if (busyPop) begin
            validAt = cyc + 1;
            if (empty) {expStat, expData} = {4'b1000, 8'h00};
            else       {expStat, expData} = {1'b0, fifoQ[0].err, fifoQ[0].data};
        end
        // A flush ends on an empty FIFO or once it has run 17 cycles.
        if (busyFlush && (empty || (cyc - flushStart + 1) == 17)) flushOn = 0;
        idle = !busyPop && !busyFlush;
        if ((idle || busyPop) && flushReq) begin
            flushOn = 1;
            flushStart = cyc + 1;
        end else if (idle && cpuRead) begin
            popCyc = cyc + 1;
        end
        nIrq  = eIrqData | eIrqTo | eIrqLs;
        nData = fifoQ.size() >= level(triggerSel);
        nTo   = (quiet == TO) && !empty;
        if (rxWe || eRe || empty) quiet = 0;
        else if (charTick && quiet < TO) quiet++;
        nLs = eIrqLs;
        if (lsrRead) nLs = 0;
        else if (fifoError && lastLsr < cyc - 2) nLs = 1;
        if (lsrRead) lastLsr = cyc;
        doRe = fifoRe; doWe = rxWe; doClr = clearError;

        @(posedge clock);
        #1;
        if (doClr && fifoQ.size() > 0) begin
            e = fifoQ[0];
            e.rep = 1'b1;
            fifoQ[0] = e;
        end
        if (doRe && fifoQ.size() > 0) void'(fifoQ.pop_front());
        if (doWe && fifoQ.size() < 16) begin
            e.data = wrData; e.err = wrErr; e.rep = 1'b0;
            fifoQ.push_back(e);
        end
        driveFifo();
        eIrqData = nData; eIrqTo = nTo; eIrqLs = nLs; eIrq = nIrq;
        cyc++;
        cpuRead = 0; lsrRead = 0; flushReq = 0; charTick = 0; rxWe = 0; wrErr = 3'b000;
    endtask

    task automatic idleN(input int n);
        repeat (n) cycle();
    endtask

    task automatic writeByte(input logic [7:0] d, input logic [2:0] er);
        rxWe = 1; wrData = d; wrErr = er;
        cycle();
    endtask

    task automatic readByte();
        cpuRead = 1;
        idleN(3);
    endtask

    task automatic doReset(input string tag);
        @(negedge clock);
        reset = 0;
        #1;
        checkAllZero(tag);
        @(posedge clock);
        #1;
        fifoQ.delete();
        driveFifo();
        clearModel();
        reset = 1;
        cyc++;
    endtask

    initial begin
        driveFifo();
        @(posedge clock);
        #1;
        checkAllZero("reset");
        reset = 1;
        cyc = 1;

        // Two bytes read back in order, exactly two pops
        writeByte(8'h41, 3'b000);
        writeByte(8'h42, 3'b000);
        rePulses = 0; readLog.delete();
        cpuRead = 1; cycle(); idleN(2);
        cpuRead = 1; cycle(); idleN(3);
        checkVal("t1.reads", 32'(readLog.size()), 2);
        if (readLog.size() == 2) begin
            checkVal("t1.first",  32'(readLog[0]), 32'h041);
            checkVal("t1.second", 32'(readLog[1]), 32'h042);
        end
        checkVal("t1.pops", 32'(rePulses), 2);
        checkVal("t1.entries", 32'(nrOfEntries), 0);

        // Read of an empty FIFO while a byte arrives in the POP cycle
        rePulses = 0;
        cpuRead = 1; cycle();
        rxWe = 1; wrData = 8'h55; cycle();
        idleN(2);
        checkVal("t2.pops", 32'(rePulses), 0);
        checkVal("t2.result", 32'(readLog[$]), 32'h800);
        checkVal("t2.entries", 32'(nrOfEntries), 1);
        readByte();
        checkVal("t2.drain", 32'(readLog[$]), 32'h055);

        // Trigger level 4
        triggerSel = 2'd1;
        for (int i = 0; i < 3; i++) writeByte(8'(8'h10 + i), 3'b000);
        idleN(2);
        checkVal("t3.at3", 32'(irqData), 0);
        writeByte(8'h13, 3'b000);
        checkVal("t3.edge", 32'(irqData), 0);
        cycle();
        checkVal("t3.at4", 32'(irqData), 1);
        readByte();
        checkVal("t3.after", 32'(irqData), 0);
        flushReq = 1; idleN(6);

        // Character timeout
        triggerSel = 2'd3;
        writeByte(8'h77, 3'b000);
        for (int i = 0; i < 3; i++) begin charTick = 1; cycle(); cycle(); end
        checkVal("t4.three", 32'(irqTimeout), 0);
        charTick = 1; cycle(); cycle();
        checkVal("t4.four", 32'(irqTimeout), 1);
        writeByte(8'h78, 3'b000);
        cycle();
        checkVal("t4.rxWe", 32'(irqTimeout), 0);
        for (int i = 0; i < 4; i++) begin charTick = 1; cycle(); end
        cycle();
        checkVal("t4.again", 32'(irqTimeout), 1);
        readByte();
        checkVal("t4.read", 32'(irqTimeout), 0);
        readByte();

        // Line status
        writeByte(8'h33, 3'b010);
        idleN(2);
        checkVal("t5.set", 32'(irqLineStatus), 1);
        lsrRead = 1; cycle();
        checkVal("t5.clrPulse", 32'(clearError), 1);
        checkVal("t5.cleared", 32'(irqLineStatus), 0);
        idleN(4);
        checkVal("t5.stays", 32'(irqLineStatus), 0);
        readByte();
        checkVal("t5.status", 32'(readLog[$]), 32'h233);

        // Full flush with a simultaneous read request
        triggerSel = 2'd0;
        for (int i = 0; i < 16; i++) writeByte(8'(i), 3'b000);
        checkVal("t6.full", 32'(nrOfEntries), 16);
        rePulses = 0; flushCycles = 0; readLog.delete();
        flushReq = 1; cpuRead = 1; cycle();
        idleN(20);
        checkVal("t6.busy", 32'(flushCycles), 17);
        checkVal("t6.pops", 32'(rePulses), 16);
        checkVal("t6.noread", 32'(readLog.size()), 0);
        checkVal("t6.entries", 32'(nrOfEntries), 0);

        // Reset in the middle of a flush
        for (int i = 0; i < 8; i++) writeByte(8'(8'h80 + i), 3'b001);
        flushReq = 1; cycle();
        idleN(3);
        doReset("midFlush");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 30) begin
                rxWe = 1;
                wrData = 8'($urandom);
                wrErr = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end
            cpuRead  = ($urandom_range(0, 99) < 15);
            lsrRead  = ($urandom_range(0, 99) < 4);
            flushReq = ($urandom_range(0, 99) < 2);
            charTick = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) == 0) triggerSel = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
